// File: rtl/uart_frame_uploader_pkg.sv
// Shared definitions for the status-frame uploader: FSM states, checksum modes, default headers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_frame_uploader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_LOAD      = 3'd1,
      ST_SETUP     = 3'd2,
      ST_STROBE    = 3'd3,
      ST_WAIT_DONE = 3'd4,
      ST_NEXT      = 3'd5
   } upl_state_e;

   localparam int CHK_SUM = 0;
   localparam int CHK_XOR = 1;

   localparam logic [7:0] HDR0_DEFAULT = 8'hAF;
   localparam logic [7:0] HDR1_DEFAULT = 8'hFA;

   // One checksum accumulation step; the sum is truncated to 8 bits.
   function automatic logic [7:0] chk_step(input logic [7:0] acc, input logic [7:0] b, input int mode);
      return (mode == CHK_XOR) ? (acc ^ b) : (acc + b);
   endfunction

endpackage

// File: rtl/uart_frame_uploader_period_timer.sv
// Free-running period timer: counts 0..PERIOD_CYC-1 while enabled and flags the last count.
// Latency: tick is combinational from the count register; first tick PERIOD_CYC cycles after enable rises.
// Backpressure: none; ticks are never held, the consumer drops what it cannot take.
//  Ports: sys_clk, sys_rst_n (async, active-low), enable (run / hold at 0), tick (1-cycle period strobe).
module upload_period_timer
   import uart_frame_uploader_pkg::*;
#(
   parameter int CLK_FREQ  = 50_000_000,
   parameter int PERIOD_MS = 1000
) (
   input  logic sys_clk,
   input  logic sys_rst_n,
   input  logic enable,
   output logic tick
);

   localparam int PERIOD_CYC = CLK_FREQ / 1000 * PERIOD_MS;
   localparam int CNT_W      = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PERIOD_CYC - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = '0;
      if (enable) begin
         cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = enable && (cnt_q == CNT_MAX);

endmodule

// File: rtl/uart_frame_uploader.sv
// Periodic / triggered status-frame uploader driving a uart_send byte transmitter.
// Latency: start request to first send_en rise = 3 cycles with tx_busy low; frame = PAYLOAD_LEN+4 bytes.
// Backpressure: each byte waits for tx_busy low before setup and holds send_en until tx_busy rises
//  (or BUSY_TMO expires); start requests while a frame is in flight are dropped and flagged on overrun.
//  Ports: sys_clk/sys_rst_n; enable (periodic mode), trig (manual start), payload (status snapshot source),
//  tx_busy (transmitter busy); send_en/send_data (byte request), frame_busy, frame_done, overrun, tx_err,
//  frame_cnt (completed frames, wrapping).
module uart_frame_uploader
   import uart_frame_uploader_pkg::*;
#(
   parameter int         CLK_FREQ    = 50_000_000,
   parameter int         PERIOD_MS   = 1000,
   parameter int         PAYLOAD_LEN = 8,
   parameter logic [7:0] HDR0        = HDR0_DEFAULT,
   parameter logic [7:0] HDR1        = HDR1_DEFAULT,
   parameter int         CHK_MODE    = CHK_SUM,
   parameter int         BUSY_TMO    = 16
) (
   input  logic                     sys_clk,
   input  logic                     sys_rst_n,
   input  logic                     enable,
   input  logic                     trig,
   input  logic [PAYLOAD_LEN*8-1:0] payload,
   input  logic                     tx_busy,
   output logic                     send_en,
   output logic [7:0]               send_data,
   output logic                     frame_busy,
   output logic                     frame_done,
   output logic                     overrun,
   output logic                     tx_err,
   output logic [15:0]              frame_cnt
);

   localparam int NBYTES = PAYLOAD_LEN + 4;
   localparam int IDX_W  = $clog2(NBYTES);
   localparam int TMO_W  = $clog2(BUSY_TMO + 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES - 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(BUSY_TMO - 1);
   localparam logic [TMO_W-1:0] TMO_MAX  = {TMO_W{1'b1}};
   localparam logic [7:0]       LEN_BYTE = 8'(PAYLOAD_LEN);

   logic tick;

   upload_period_timer #(
      .CLK_FREQ (CLK_FREQ),
      .PERIOD_MS(PERIOD_MS)
   ) u_timer (
      .sys_clk  (sys_clk),
      .sys_rst_n(sys_rst_n),
      .enable   (enable),
      .tick     (tick)
   );

   upl_state_e               state_q, state_d;
   logic [IDX_W-1:0]         idx_q, idx_d;
   logic [7:0]               chk_q, chk_d;
   logic [TMO_W-1:0]         tmo_q, tmo_d;
   logic [PAYLOAD_LEN*8-1:0] payload_q, payload_d;
   logic                     send_en_q, send_en_d;
   logic [7:0]               send_data_q, send_data_d;
   logic                     frame_busy_q, frame_busy_d;
   logic                     frame_done_q, frame_done_d;
   logic                     overrun_q, overrun_d;
   logic                     tx_err_q, tx_err_d;
   logic [15:0]              frame_cnt_q, frame_cnt_d;

   logic                     start_req;
   logic [7:0]               chk_upd;

   // Byte at frame position idx; the last position carries the running checksum.
   function automatic logic [7:0] frame_byte(input logic [IDX_W-1:0] idx,
                                             input logic [PAYLOAD_LEN*8-1:0] pl,
                                             input logic [7:0] chk);
      logic [IDX_W-1:0]         off;
      logic [PAYLOAD_LEN*8-1:0] sh;
      logic [7:0]               b;
      off = idx - IDX_W'(3);
      sh  = pl >> {off, 3'b000};
      b   = chk;
      if (idx == IDX_W'(0))      b = HDR0;
      else if (idx == IDX_W'(1)) b = HDR1;
      else if (idx == IDX_W'(2)) b = LEN_BYTE;
      else if (idx < IDX_LAST)   b = sh[7:0];
      return b;
   endfunction

   assign start_req = tick | trig;

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      chk_d        = chk_q;
      tmo_d        = tmo_q;
      payload_d    = payload_q;
      send_en_d    = send_en_q;
      send_data_d  = send_data_q;
      frame_busy_d = frame_busy_q;
      frame_done_d = 1'b0;
      overrun_d    = 1'b0;
      tx_err_d     = 1'b0;
      frame_cnt_d  = frame_cnt_q;
      chk_upd      = chk_q;

      // tick and trig together are a single request, so they share one overrun pulse.
      if (start_req && (state_q != ST_IDLE)) begin
         overrun_d = 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            if (start_req) begin
               state_d      = ST_LOAD;
               payload_d    = payload;
               idx_d        = '0;
               chk_d        = '0;
               frame_busy_d = 1'b1;
            end
         end
         ST_LOAD: begin
            if (!tx_busy) begin
               // send_data is loaded on entry to SETUP so it is stable a full cycle before send_en.
               state_d     = ST_SETUP;
               send_data_d = frame_byte(idx_q, payload_q, chk_q);
            end
         end
         ST_SETUP: begin
            state_d   = ST_STROBE;
            send_en_d = 1'b1;
            tmo_d     = '0;
         end
         ST_STROBE: begin
            if (tx_busy) begin
               send_en_d = 1'b0;
               state_d   = ST_WAIT_DONE;
            end else if (tmo_q >= TMO_LAST) begin
               // Transmitter never acknowledged: report it and move on as if the byte went out.
               send_en_d = 1'b0;
               tx_err_d  = 1'b1;
               state_d   = ST_NEXT;
            end else if (tmo_q != TMO_MAX) begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end
         ST_WAIT_DONE: begin
            if (!tx_busy) begin
               state_d = ST_NEXT;
            end
         end
         ST_NEXT: begin
            // Only LEN and payload bytes feed the checksum; headers and the checksum byte itself do not.
            if ((idx_q >= IDX_W'(2)) && (idx_q < IDX_LAST)) begin
               chk_upd = chk_step(chk_q, frame_byte(idx_q, payload_q, chk_q), CHK_MODE);
            end
            chk_d = chk_upd;
            if (idx_q == IDX_LAST) begin
               frame_done_d = 1'b1;
               frame_cnt_d  = frame_cnt_q + 16'd1;
               frame_busy_d = 1'b0;
               state_d      = ST_IDLE;
            end else begin
               // chk_upd already includes the byte just sent, so the checksum byte is complete here.
               idx_d       = idx_q + IDX_W'(1);
               send_data_d = frame_byte(idx_q + IDX_W'(1), payload_q, chk_upd);
               state_d     = ST_SETUP;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q      <= ST_IDLE;
         idx_q        <= '0;
         chk_q        <= '0;
         tmo_q        <= '0;
         payload_q    <= '0;
         send_en_q    <= 1'b0;
         send_data_q  <= '0;
         frame_busy_q <= 1'b0;
         frame_done_q <= 1'b0;
         overrun_q    <= 1'b0;
         tx_err_q     <= 1'b0;
         frame_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         chk_q        <= chk_d;
         tmo_q        <= tmo_d;
         payload_q    <= payload_d;
         send_en_q    <= send_en_d;
         send_data_q  <= send_data_d;
         frame_busy_q <= frame_busy_d;
         frame_done_q <= frame_done_d;
         overrun_q    <= overrun_d;
         tx_err_q     <= tx_err_d;
         frame_cnt_q  <= frame_cnt_d;
      end
   end

   assign send_en    = send_en_q;
   assign send_data  = send_data_q;
   assign frame_busy = frame_busy_q;
   assign frame_done = frame_done_q;
   assign overrun    = overrun_q;
   assign tx_err     = tx_err_q;
   assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_uart_frame_uploader.sv
// Bench for uart_frame_uploader: sum and XOR checksum instances share stimulus and a uart_send model.
// Latency: n/a.
// Backpressure: uart_send model raises tx_busy one cycle after a send_en rise, for 10 cycles.
module tb_uart_frame_uploader;

   localparam int PL   = 3;
   localparam int NB   = PL + 4;
   localparam int PCYC = 500;
   localparam int TMO  = 16;

   logic            sys_clk = 1'b0;
   logic            sys_rst_n = 1'b0;
   logic            enable = 1'b0;
   logic            trig = 1'b0;
   logic            tx_busy = 1'b0;
   logic [PL*8-1:0] payload = '0;
   logic            send_en, frame_busy, frame_done, overrun, tx_err;
   logic [7:0]      send_data;
   logic [15:0]     frame_cnt;
   logic            x_send_en, x_frame_busy, x_frame_done, x_overrun, x_tx_err;
   logic [7:0]      x_send_data;
   logic [15:0]     x_frame_cnt;

   bit              tx_stuck = 1'b0;
   int              nvec = 0;
   int              nfail = 0;
   int              rises = 0;
   int              txerr_seen = 0;
   int              max_run = 0;
   int              cyc = 0;
   logic [7:0]      cap[$];
   logic [7:0]      capx[$];
   logic [7:0]      exp1[NB];

   always #5 sys_clk = ~sys_clk;

   uart_frame_uploader #(.CLK_FREQ(500_000), .PERIOD_MS(1), .PAYLOAD_LEN(PL), .HDR0(8'hAF), .HDR1(8'hFA),
                         .CHK_MODE(0), .BUSY_TMO(TMO)) dut (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .enable(enable), .trig(trig), .payload(payload),
      .tx_busy(tx_busy), .send_en(send_en), .send_data(send_data), .frame_busy(frame_busy),
      .frame_done(frame_done), .overrun(overrun), .tx_err(tx_err), .frame_cnt(frame_cnt));

   uart_frame_uploader #(.CLK_FREQ(500_000), .PERIOD_MS(1), .PAYLOAD_LEN(PL), .HDR0(8'hAF), .HDR1(8'hFA),
                         .CHK_MODE(1), .BUSY_TMO(TMO)) dut_x (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .enable(enable), .trig(trig), .payload(payload),
      .tx_busy(tx_busy), .send_en(x_send_en), .send_data(x_send_data), .frame_busy(x_frame_busy),
      .frame_done(x_frame_done), .overrun(x_overrun), .tx_err(x_tx_err), .frame_cnt(x_frame_cnt));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) @(posedge sys_clk);
      #1;
   endtask

   // Reference frame: headers, length, payload LSB byte first, then checksum over LEN + payload.
   function automatic logic [7:0] fbyte(input logic [PL*8-1:0] p, input int k, input bit xm);
      logic [7:0] c;
      logic [7:0] b;
      if (k == 0) return 8'hAF;
      if (k == 1) return 8'hFA;
      if (k == 2) return 8'(PL);
      if (k < NB - 1) return p[8*(k-3) +: 8];
      c = 8'(PL);
      for (int i = 0; i < PL; i++) begin
         b = p[8*i +: 8];
         c = xm ? (c ^ b) : 8'(c + b);
      end
      return c;
   endfunction

   initial forever begin
      @(posedge sys_clk);
      cyc++;
   end

   // uart_send model
   initial begin : tx_model
      bit en_prev;
      bit pend;
      int left;
      en_prev = 0; pend = 0; left = 0;
      forever begin
         @(posedge sys_clk);
         #1;
         if (!sys_rst_n) begin
            tx_busy = 1'b0; en_prev = 0; pend = 0; left = 0;
         end else begin
            if (pend) begin
               pend = 0; tx_busy = 1'b1; left = 10;
            end else if (left > 0) begin
               left--;
               if (left == 0) tx_busy = 1'b0;
            end
            if (send_en && !en_prev && !tx_stuck) pend = 1;
            en_prev = send_en;
         end
      end
   end

   // Behavioural model + per-cycle compare
   initial begin : cmp
      logic [7:0]  q_e[$];
      logic [7:0]  q_x[$];
      bit          mbusy, exp_ovr, exp_txerr, req, prev_en, prev_en_x;
      logic [7:0]  prev_data, prev_data_x;
      logic [15:0] mcnt;
      int          tcnt, en_run;
      mbusy = 0; exp_ovr = 0; exp_txerr = 0; prev_en = 0; prev_en_x = 0;
      prev_data = '0; prev_data_x = '0; mcnt = '0; tcnt = 0; en_run = 0;
      forever begin
         @(negedge sys_clk);
         if (!sys_rst_n) begin
            q_e.delete(); q_x.delete();
            mbusy = 0; exp_ovr = 0; exp_txerr = 0; prev_en = 0; prev_en_x = 0;
            prev_data = '0; prev_data_x = '0; mcnt = '0; tcnt = 0; en_run = 0;
            continue;
         end
         if (frame_done) begin
            chk("done_inside_frame", 32'(mbusy), 32'(1));
            chk("done_all_bytes_sent", 32'(q_e.size()), 0);
            chk("x_done_all_bytes_sent", 32'(q_x.size()), 0);
            q_e.delete(); q_x.delete();
            mbusy = 0;
            mcnt  = mcnt + 16'd1;
         end
         chk("frame_cnt", 32'(frame_cnt), 32'(mcnt));
         chk("x_frame_cnt", 32'(x_frame_cnt), 32'(mcnt));
         chk("frame_busy", 32'(frame_busy), 32'(mbusy));
         chk("x_frame_busy", 32'(x_frame_busy), 32'(mbusy));
         chk("overrun", 32'(overrun), 32'(exp_ovr));
         chk("x_overrun", 32'(x_overrun), 32'(exp_ovr));
         chk("tx_err", 32'(tx_err), 32'(exp_txerr));
         chk("x_tx_err", 32'(x_tx_err), 32'(exp_txerr));
         if (tx_err) txerr_seen++;
         if (send_en && !prev_en) begin
            rises++;
            chk("data_stable_before_send_en", 32'(send_data), 32'(prev_data));
            chk("byte_expected", 32'(q_e.size() != 0), 32'(1));
            if (q_e.size() != 0) chk("byte_value", 32'(send_data), 32'(q_e.pop_front()));
            cap.push_back(send_data);
         end
         if (x_send_en && !prev_en_x) begin
            chk("x_data_stable_before_send_en", 32'(x_send_data), 32'(prev_data_x));
            chk("x_byte_expected", 32'(q_x.size() != 0), 32'(1));
            if (q_x.size() != 0) chk("x_byte_value", 32'(x_send_data), 32'(q_x.pop_front()));
            capx.push_back(x_send_data);
         end
         en_run = send_en ? en_run + 1 : 0;
         if (en_run > max_run) max_run = en_run;
         if (send_en) chk("send_en_hold_bounded", 32'(en_run <= TMO), 32'(1));
         // The BUSY_TMO-th strobe cycle without tx_busy ends the byte with an error.
         exp_txerr = send_en && (en_run == TMO) && !tx_busy;
         req     = trig || (enable && (tcnt == PCYC - 1));
         exp_ovr = req && mbusy;
         if (req && !mbusy) begin
            for (int k = 0; k < NB; k++) begin
               q_e.push_back(fbyte(payload, k, 1'b0));
               q_x.push_back(fbyte(payload, k, 1'b1));
            end
            mbusy = 1;
         end
         tcnt = enable ? ((tcnt == PCYC - 1) ? 0 : tcnt + 1) : 0;
         prev_en = send_en; prev_en_x = x_send_en;
         prev_data = send_data; prev_data_x = x_send_data;
      end
   end

   task automatic wait_done(input int bound, input string name);
      int n;
      n = 0;
      while (!frame_done && n < bound) begin
         step();
         n++;
      end
      chk({name, "_done_seen"}, 32'(frame_done), 32'(1));
      step();
   endtask

   task automatic check_frame1(input string name);
      chk({name, "_byte_count"}, 32'(cap.size()), NB);
      for (int i = 0; i < NB && i < cap.size(); i++) chk({name, "_byte"}, 32'(cap[i]), 32'(exp1[i]));
      chk({name, "_xor_chk_byte"}, 32'(capx.size() == NB ? capx[NB-1] : 8'h00), 32'h03);
   endtask

   task automatic pulse_trig();
      trig = 1'b1;
      step();
      trig = 1'b0;
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, nvec=%0d nfail=%0d", nvec, nfail);
      $fatal(1);
   end

   initial begin : stim
      int lat, n, r0, e0, t_en, t1, t2, starts;
      exp1 = '{8'hAF, 8'hFA, 8'h03, 8'h01, 8'h02, 8'h03, 8'h09};

      // Reset state
      step(3);
      chk("rst_send_en", 32'(send_en), 0);
      chk("rst_send_data", 32'(send_data), 0);
      chk("rst_frame_busy", 32'(frame_busy), 0);
      chk("rst_frame_done", 32'(frame_done), 0);
      chk("rst_overrun", 32'(overrun), 0);
      chk("rst_tx_err", 32'(tx_err), 0);
      chk("rst_frame_cnt", 32'(frame_cnt), 0);
      sys_rst_n = 1'b1;
      step(2);

      // Basic triggered frame
      payload = 24'h030201;
      cap.delete(); capx.delete();
      pulse_trig();
      lat = 1;
      while (!send_en && lat < 20) begin
         step();
         lat++;
      end
      chk("first_send_latency", 32'(lat), 3);
      wait_done(400, "f1");
      check_frame1("f1");
      chk("f1_frame_cnt", 32'(frame_cnt), 1);

      // Overrun and payload snapshot
      cap.delete(); capx.delete();
      pulse_trig();
      step(20);
      payload = 24'hFFEEDD;
      pulse_trig();
      chk("overrun_pulse", 32'(overrun), 1);
      step();
      chk("overrun_one_cycle", 32'(overrun), 0);
      wait_done(400, "f2");
      check_frame1("f2_snapshot");
      chk("f2_frame_cnt", 32'(frame_cnt), 2);

      // Periodic mode
      enable = 1'b1;
      t_en = cyc;
      n = 0;
      while (!frame_busy && n < 700) begin step(); n++; end
      t1 = cyc;
      chk("first_tick_delay", 32'(t1 - t_en), PCYC);
      n = 0;
      while (frame_busy && n < 400) begin step(); n++; end
      n = 0;
      while (!frame_busy && n < 700) begin step(); n++; end
      t2 = cyc;
      chk("tick_period", 32'(t2 - t1), PCYC);
      step(30);
      enable = 1'b0;
      wait_done(400, "disable_midframe");
      starts = 0;
      for (int i = 0; i < 1200; i++) begin
         step();
         if (frame_busy) starts++;
      end
      chk("no_start_when_disabled", 32'(starts), 0);

      // Transmitter never answers
      tx_stuck = 1'b1;
      r0 = rises; e0 = txerr_seen; max_run = 0;
      payload = 24'($urandom);
      pulse_trig();
      wait_done(NB * (TMO + 6) + 40, "stuck");
      chk("stuck_strobes", 32'(rises - r0), NB);
      chk("stuck_tx_err_pulses", 32'(txerr_seen - e0), NB);
      chk("stuck_send_en_hold", 32'(max_run), TMO);
      tx_stuck = 1'b0;
      step(3);

      // Async reset mid-frame
      payload = 24'h030201;
      r0 = rises;
      pulse_trig();
      n = 0;
      while ((rises - r0) < 4 && n < 300) begin step(); n++; end
      step(2);
      #2;
      sys_rst_n = 1'b0;
      #1;
      chk("midrst_send_en", 32'(send_en), 0);
      chk("midrst_send_data", 32'(send_data), 0);
      chk("midrst_frame_busy", 32'(frame_busy), 0);
      chk("midrst_frame_done", 32'(frame_done), 0);
      chk("midrst_overrun", 32'(overrun), 0);
      chk("midrst_tx_err", 32'(tx_err), 0);
      chk("midrst_frame_cnt", 32'(frame_cnt), 0);
      step(2);
      sys_rst_n = 1'b1;
      step(2);
      cap.delete(); capx.delete();
      pulse_trig();
      wait_done(400, "after_rst");
      check_frame1("after_rst");
      chk("after_rst_frame_cnt", 32'(frame_cnt), 1);

      // Randomized traffic against the model
      enable = 1'b1;
      for (int i = 0; i < 8000; i++) begin
         trig = ($urandom_range(0, 59) == 0);
         if ($urandom_range(0, 7) == 0) payload = 24'($urandom);
         if ($urandom_range(0, 999) == 0) enable = ~enable;
         step();
      end
      trig = 1'b0;
      enable = 1'b0;
      n = 0;
      while (frame_busy && n < 500) begin step(); n++; end
      chk("drain_idle", 32'(frame_busy), 0);
      step(5);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
